infix_to_postfix: RTL and testbench

- Front-end stage that directly feeds the postfix evaluator.
- Accepts an infix token stream, buffers it, and converts it with a shunting-yard operator stack.
- Replays the resulting postfix sequence as one contiguous valid burst using the evaluator's token encoding (OUT/OP_MODE/OUT_VALID map onto its IN/OP_MODE/IN_VALID).
- The evaluator detects end-of-expression on valid falling, so output must never have bubbles.

---
 rtl/infix_to_postfix.sv | 217 +++++++++++++++++++++
 tb/tb_infix_to_postfix.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/infix_to_postfix.sv
// infix_to_postfix: buffers one infix token burst, converts it with a
// shunting-yard operator stack and replays the postfix form as a single
// gap-free OUT_VALID burst for the downstream postfix evaluator.
// Build option: define INFIX_PAREN_EN to enable '(' / ')' handling.
//
// state   | meaning
// IDLE    | waiting for the first token of an expression
// LOAD    | appending tokens while IN_VALID stays high
// CONVERT | one shunting-yard action per cycle
// FLUSH   | draining the operator stack into the output queue
// EMIT    | replaying the output queue, one token per cycle
module infix_to_postfix #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 5
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] IN,
    input  logic       IN_MODE,
    input  logic       IN_VALID,
    output logic [3:0] OUT,
    output logic       OP_MODE,
    output logic       OUT_VALID,
    output logic       BUSY,
    output logic       ERR
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] CNT_MAX = PTR_W'(DEPTH);
    localparam logic [IDX_W-1:0] IDX0    = '0;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_CONVERT = 3'd2;
    localparam logic [2:0] S_FLUSH   = 3'd3;
    localparam logic [2:0] S_EMIT    = 3'd4;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
`ifdef INFIX_PAREN_EN
    localparam logic [3:0] OP_LPAR = 4'b1000;
    localparam logic [3:0] OP_RPAR = 4'b1001;
`endif

    logic [2:0]       state;
    logic [4:0]       in_buf [DEPTH];   // {mode, token}
    logic [4:0]       q_buf  [DEPTH];   // {mode, token}, postfix order
    logic [3:0]       stk    [DEPTH];   // operator codes (and '(' when enabled)
    logic [PTR_W-1:0] in_cnt;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_m1;
    logic [PTR_W-1:0] q_cnt;
    logic [PTR_W-1:0] q_ptr;
    logic [4:0]       cur;
    logic [3:0]       top;
    logic             top_is_op;

    function automatic logic is_op_code(input logic [3:0] c);
`ifdef INFIX_PAREN_EN
        return (c == OP_ADD) || (c == OP_SUB) || (c == OP_MUL) ||
               (c == OP_LPAR) || (c == OP_RPAR);
`else
        return (c == OP_ADD) || (c == OP_SUB) || (c == OP_MUL);
`endif
    endfunction

    function automatic logic [1:0] prec(input logic [3:0] c);
        return (c == OP_MUL) ? 2'd2 : 2'd1;
    endfunction

    assign sp_m1 = sp - 1'b1;
    assign cur   = in_buf[rd_ptr[IDX_W-1:0]];
    assign top   = stk[sp_m1[IDX_W-1:0]];
`ifdef INFIX_PAREN_EN
    assign top_is_op = (top != OP_LPAR);
`else
    assign top_is_op = 1'b1;
`endif

    // Sequencer: capture, convert, flush and replay one expression at a time.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= S_IDLE;
            in_cnt    <= '0;
            rd_ptr    <= '0;
            sp        <= '0;
            q_cnt     <= '0;
            q_ptr     <= '0;
            OUT       <= '0;
            OP_MODE   <= 1'b0;
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        in_buf[IDX0] <= {IN_MODE, IN};
                        in_cnt       <= PTR_W'(1);
                        ERR          <= IN_MODE & ~is_op_code(IN);
                        BUSY         <= 1'b1;
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (IN_VALID) begin
                        if (in_cnt == CNT_MAX) begin
                            ERR <= 1'b1;
                        end else begin
                            in_buf[in_cnt[IDX_W-1:0]] <= {IN_MODE, IN};
                            in_cnt <= in_cnt + 1'b1;
                            if (IN_MODE && !is_op_code(IN)) ERR <= 1'b1;
                        end
                    end else begin
                        rd_ptr <= '0;
                        sp     <= '0;
                        q_cnt  <= '0;
                        state  <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    if (rd_ptr == in_cnt) begin
                        state <= S_FLUSH;
                    end else if (!cur[4]) begin
                        q_buf[q_cnt[IDX_W-1:0]] <= cur;
                        q_cnt  <= q_cnt + 1'b1;
                        rd_ptr <= rd_ptr + 1'b1;
                    end else begin
                        case (cur[3:0])
                            OP_ADD, OP_SUB, OP_MUL: begin
                                if ((sp != '0) && top_is_op && (prec(top) >= prec(cur[3:0]))) begin
                                    q_buf[q_cnt[IDX_W-1:0]] <= {1'b1, top};
                                    q_cnt <= q_cnt + 1'b1;
                                    sp    <= sp_m1;
                                end else begin
                                    stk[sp[IDX_W-1:0]] <= cur[3:0];
                                    sp     <= sp + 1'b1;
                                    rd_ptr <= rd_ptr + 1'b1;
                                end
                            end
`ifdef INFIX_PAREN_EN
                            OP_LPAR: begin
                                stk[sp[IDX_W-1:0]] <= cur[3:0];
                                sp     <= sp + 1'b1;
                                rd_ptr <= rd_ptr + 1'b1;
                            end
                            OP_RPAR: begin
                                if (sp == '0) begin
                                    ERR    <= 1'b1;
                                    rd_ptr <= rd_ptr + 1'b1;
                                end else if (top == OP_LPAR) begin
                                    sp     <= sp_m1;
                                    rd_ptr <= rd_ptr + 1'b1;
                                end else begin
                                    q_buf[q_cnt[IDX_W-1:0]] <= {1'b1, top};
                                    q_cnt <= q_cnt + 1'b1;
                                    sp    <= sp_m1;
                                end
                            end
`endif
                            default: begin
                                ERR    <= 1'b1;
                                rd_ptr <= rd_ptr + 1'b1;
                            end
                        endcase
                    end
                end
                S_FLUSH: begin
                    if (sp == '0) begin
                        q_ptr <= '0;
                        if (ERR) begin
                            BUSY  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_EMIT;
                        end
                    end else begin
                        sp <= sp_m1;
`ifdef INFIX_PAREN_EN
                        if (top == OP_LPAR) begin
                            ERR <= 1'b1;
                        end else begin
                            q_buf[q_cnt[IDX_W-1:0]] <= {1'b1, top};
                            q_cnt <= q_cnt + 1'b1;
                        end
`else
                        q_buf[q_cnt[IDX_W-1:0]] <= {1'b1, top};
                        q_cnt <= q_cnt + 1'b1;
`endif
                    end
                end
                S_EMIT: begin
                    if (q_ptr < q_cnt) begin
                        OUT       <= q_buf[q_ptr[IDX_W-1:0]][3:0];
                        OP_MODE   <= q_buf[q_ptr[IDX_W-1:0]][4];
                        OUT_VALID <= 1'b1;
                        q_ptr     <= q_ptr + 1'b1;
                    end else begin
                        OUT       <= '0;
                        OP_MODE   <= 1'b0;
                        OUT_VALID <= 1'b0;
                        BUSY      <= 1'b0;
                        state     <= S_IDLE;
                        if (q_cnt == '0) ERR <= 1'b1;
                    end
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_infix_to_postfix.sv
// Bench for infix_to_postfix: directed expressions plus random token streams
// checked against a queue-based shunting-yard reference model.
module tb_infix_to_postfix;

    localparam int DEPTH = 16;
`ifdef INFIX_PAREN_EN
    localparam bit PAREN = 1'b1;
`else
    localparam bit PAREN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] IN = '0;
    logic       IN_MODE = 1'b0;
    logic       IN_VALID = 1'b0;
    logic [3:0] OUT;
    logic       OP_MODE;
    logic       OUT_VALID;
    logic       BUSY;
    logic       ERR;

    int n_assert = 0;
    int n_fail   = 0;

    logic [4:0] stim[$];
    logic [4:0] exp_q[$];
    logic [4:0] got_q[$];
    logic       exp_err;

    infix_to_postfix #(.DEPTH(DEPTH), .PTR_W(5)) dut (
        .CLK(CLK), .RESET(RESET), .IN(IN), .IN_MODE(IN_MODE), .IN_VALID(IN_VALID),
        .OUT(OUT), .OP_MODE(OP_MODE), .OUT_VALID(OUT_VALID), .BUSY(BUSY), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] num(input int v);
        return {1'b0, 4'(v)};
    endfunction

    function automatic logic [4:0] opr(input int c);
        return {1'b1, 4'(c)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int prec(input logic [3:0] c);
        return (c == 4'd4) ? 2 : 1;
    endfunction

    // Reference: textbook shunting-yard over queues, plus error rules.
    task automatic model();
        logic [3:0] st[$];
        logic [3:0] tmp;
        logic [4:0] t;
        int n;
        exp_q.delete();
        exp_err = 1'b0;
        n = stim.size();
        if (n > DEPTH) begin
            exp_err = 1'b1;
            n = DEPTH;
        end
        for (int i = 0; i < n; i++) begin
            t = stim[i];
            if (!t[4]) begin
                exp_q.push_back(t);
            end else if (t[3:0] == 4'd1 || t[3:0] == 4'd2 || t[3:0] == 4'd4) begin
                while (st.size() > 0 && st[$] != 4'd8 && prec(st[$]) >= prec(t[3:0]))
                    exp_q.push_back({1'b1, st.pop_back()});
                st.push_back(t[3:0]);
            end else if (PAREN && t[3:0] == 4'd8) begin
                st.push_back(4'd8);
            end else if (PAREN && t[3:0] == 4'd9) begin
                while (st.size() > 0 && st[$] != 4'd8)
                    exp_q.push_back({1'b1, st.pop_back()});
                if (st.size() == 0) exp_err = 1'b1;
                else tmp = st.pop_back();
            end else begin
                exp_err = 1'b1;
            end
        end
        while (st.size() > 0) begin
            tmp = st.pop_back();
            if (tmp == 4'd8) exp_err = 1'b1;
            else exp_q.push_back({1'b1, tmp});
        end
        if (exp_q.size() == 0) exp_err = 1'b1;
        if (exp_err) exp_q.delete();
    endtask

    function automatic int eval_got();
        int s[$];
        int a, b;
        foreach (got_q[i]) begin
            if (!got_q[i][4]) begin
                s.push_back(int'(got_q[i][3:0]));
            end else begin
                if (s.size() < 2) return -1;
                b = s.pop_back();
                a = s.pop_back();
                case (got_q[i][3:0])
                    4'd1:    s.push_back(a + b);
                    4'd2:    s.push_back(a - b);
                    4'd4:    s.push_back(a * b);
                    default: return -1;
                endcase
            end
        end
        return (s.size() == 1) ? s[0] : -1;
    endfunction

    task automatic send();
        for (int i = 0; i < stim.size(); i++) begin
            @(negedge CLK);
            IN       = stim[i][3:0];
            IN_MODE  = stim[i][4];
            IN_VALID = 1'b1;
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        IN       = '0;
        IN_MODE  = 1'b0;
    endtask

    task automatic collect(output bit timed_out, output bit bubble);
        bit started = 1'b0;
        bit ended = 1'b0;
        got_q.delete();
        timed_out = 1'b1;
        bubble = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (OUT_VALID === 1'b1) begin
                if (ended) bubble = 1'b1;
                started = 1'b1;
                got_q.push_back({OP_MODE, OUT});
            end else if (started) begin
                ended = 1'b1;
            end
            if (BUSY === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic verify(input string tag, input int exp_val);
        bit to, bub;
        int m;
        collect(to, bub);
        check({tag, " timeout"}, 32'(to), 32'd0);
        check({tag, " err"}, 32'(ERR), 32'(exp_err));
        check({tag, " len"}, 32'(got_q.size()), 32'(exp_q.size()));
        check({tag, " bubble"}, 32'(bub), 32'd0);
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            check({tag, " tok"}, 32'(got_q[i]), 32'(exp_q[i]));
        if (exp_val >= 0 && !exp_err)
            check({tag, " result"}, 32'(eval_got()), 32'(exp_val));
    endtask

    function automatic logic [4:0] rand_op();
        case ($urandom_range(0, 6))
            0, 1:    return opr(1);
            2:       return opr(2);
            3:       return opr(4);
            4:       return opr(8);
            5:       return opr(9);
            default: return opr(int'($urandom_range(0, 15)));
        endcase
    endfunction

    function automatic logic [4:0] rand_arith();
        case ($urandom_range(0, 2))
            0:       return opr(1);
            1:       return opr(2);
            default: return opr(4);
        endcase
    endfunction

    task automatic gen_random();
        int n, terms;
        stim.delete();
        if ($urandom_range(0, 2) == 0) begin
            n = $urandom_range(1, 18);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) stim.push_back(num(int'($urandom_range(0, 15))));
                else stim.push_back(rand_op());
            end
        end else begin
            terms = $urandom_range(1, 4);
            for (int t = 0; t < terms; t++) begin
                if (t > 0) stim.push_back(rand_arith());
                if ($urandom_range(0, 3) == 0) begin
                    stim.push_back(opr(8));
                    stim.push_back(num(int'($urandom_range(0, 15))));
                    stim.push_back(rand_arith());
                    stim.push_back(num(int'($urandom_range(0, 15))));
                    stim.push_back(opr(9));
                end else begin
                    stim.push_back(num(int'($urandom_range(0, 15))));
                end
            end
        end
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge CLK);
        check("reset OUT", 32'(OUT), 32'd0);
        check("reset OP_MODE", 32'(OP_MODE), 32'd0);
        check("reset OUT_VALID", 32'(OUT_VALID), 32'd0);
        check("reset BUSY", 32'(BUSY), 32'd0);
        check("reset ERR", 32'(ERR), 32'd0);
        RESET = 1'b1;
        @(negedge CLK);

        stim = {num(3), opr(1), num(4), opr(4), num(2)};
        exp_q = {num(3), num(4), num(2), opr(4), opr(1)};
        exp_err = 1'b0;
        send();
        verify("prec", 11);

        stim = {num(8), opr(2), num(3), opr(2), num(2)};
        exp_q = {num(8), num(3), opr(2), num(2), opr(2)};
        exp_err = 1'b0;
        send();
        verify("assoc", 3);

        stim = {opr(8), num(1), opr(1), num(2), opr(9), opr(4), num(3)};
`ifdef INFIX_PAREN_EN
        exp_q = {num(1), num(2), opr(1), num(3), opr(4)};
        exp_err = 1'b0;
`else
        exp_q = {};
        exp_err = 1'b1;
`endif
        send();
        verify("paren", 9);

        stim = {opr(8), num(1), opr(1), num(2)};
        exp_q = {};
        exp_err = 1'b1;
        send();
        verify("unbal_open", -1);

        stim = {num(1), opr(1), num(2), opr(9)};
        exp_q = {};
        exp_err = 1'b1;
        send();
        verify("unbal_close", -1);

        stim = {num(5)};
        exp_q = {num(5)};
        exp_err = 1'b0;
        send();
        verify("single", 5);

        stim.delete();
        for (int i = 0; i < 9; i++) begin
            if (i > 0) stim.push_back(opr(1));
            stim.push_back(num(1));
        end
        exp_q = {};
        exp_err = 1'b1;
        send();
        verify("overflow", -1);

        stim = {num(3), opr(3), num(4)};
        exp_q = {};
        exp_err = 1'b1;
        send();
        verify("bad_code", -1);

        stim = {opr(8), opr(9)};
        exp_q = {};
        exp_err = 1'b1;
        send();
        verify("empty_parens", -1);

        // Tokens offered while converting must be dropped.
        stim = {num(1), opr(1), num(2), opr(4), num(3)};
        model();
        send();
        repeat (3) begin
            @(negedge CLK);
            IN = 4'd7;
            IN_MODE = 1'b0;
            IN_VALID = 1'b1;
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        verify("busy_ignore", 7);

        // Reset in the middle of the output burst.
        stim = {num(3), opr(1), num(4), opr(4), num(2)};
        send();
        seen = 0;
        for (int c = 0; c < 100 && seen < 3; c++) begin
            @(negedge CLK);
            if (OUT_VALID === 1'b1) seen++;
        end
        check("rst_emit reached", 32'(seen), 32'd3);
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_emit OUT_VALID", 32'(OUT_VALID), 32'd0);
        check("rst_emit BUSY", 32'(BUSY), 32'd0);
        check("rst_emit ERR", 32'(ERR), 32'd0);
        check("rst_emit OUT", 32'(OUT), 32'd0);
        RESET = 1'b1;
        @(negedge CLK);

        stim = {num(2), opr(4), num(2)};
        exp_q = {num(2), num(2), opr(4)};
        exp_err = 1'b0;
        send();
        verify("after_rst", 4);

        for (int k = 0; k < 60; k++) begin
            gen_random();
            model();
            send();
            verify("random", -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
